// File: rtl/bcd_entry_controller.sv
// bcd_entry_controller
//   Turns debounced button pulses (up/down/next/enter) into an editable
//   NUM_DIGITS-digit BCD value. One digit is edited at a time under a cursor.
//   Enter commits the value and strobes commit_valid. A quiet period during
//   editing abandons the session and restores the last committed value.
//   After a commit, all pulses are ignored for HOLD_CYCLES cycles.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   up_pulse      1-cycle pulse: increment digit under the cursor (9 wraps to 0)
//   down_pulse    1-cycle pulse: decrement digit under the cursor (0 wraps to 9)
//   next_pulse    1-cycle pulse: advance the cursor (last digit wraps to 0)
//   enter_pulse   1-cycle pulse: commit the working value
//   digits        working value, digit i at [4i+3:4i], digit 0 least significant
//   cursor        index of the digit being edited
//   editing       high while an edit session is active
//   commit_valid  1-cycle strobe, commit_value holds the new value that cycle
//   commit_value  last committed value, held between commits

module bcd_entry_controller #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int HOLD_CYCLES    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            up_pulse,
  input  logic                            down_pulse,
  input  logic                            next_pulse,
  input  logic                            enter_pulse,
  output logic [4*NUM_DIGITS-1:0]         digits,
  output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
  output logic                            editing,
  output logic                            commit_valid,
  output logic [4*NUM_DIGITS-1:0]         commit_value
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS);
  // The timer only has to reach TIMEOUT_CYCLES-1, the hold counter HOLD_CYCLES-1.
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] CURSOR_LAST  = CW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state_reg,   state_next;
  logic [DW-1:0] digits_reg,  digits_next;
  logic [DW-1:0] commit_reg,  commit_next;
  logic [CW-1:0] cursor_reg,  cursor_next;
  logic [TW-1:0] timer_reg,   timer_next;
  logic [HW-1:0] hold_reg,    hold_next;
  logic          editing_reg, editing_next;
  logic          valid_reg,   valid_next;

  logic          any_pulse;
  logic [DW-1:0] up_value;
  logic [DW-1:0] down_value;

  assign any_pulse = up_pulse | down_pulse | next_pulse | enter_pulse;

  // Candidate working values for an up or down action: only the digit under
  // the cursor changes, every other digit passes through untouched.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] cur;
    logic       sel;

    assign cur = digits_reg[4*gi +: 4];
    assign sel = (cursor_reg == CW'(gi));

    assign up_value[4*gi +: 4]   = !sel           ? cur :
                                   (cur >= 4'd9)  ? 4'd0 : cur + 4'd1;
    assign down_value[4*gi +: 4] = !sel           ? cur :
                                   (cur == 4'd0)  ? 4'd9 : cur - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      digits_reg  <= '0;
      commit_reg  <= '0;
      cursor_reg  <= '0;
      timer_reg   <= '0;
      hold_reg    <= '0;
      editing_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      digits_reg  <= digits_next;
      commit_reg  <= commit_next;
      cursor_reg  <= cursor_next;
      timer_reg   <= timer_next;
      hold_reg    <= hold_next;
      editing_reg <= editing_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    digits_next = digits_reg;
    commit_next = commit_reg;
    cursor_next = cursor_reg;
    timer_next  = timer_reg;
    hold_next   = hold_reg;

    case (state_reg)
      S_IDLE: begin
        // The waking pulse only opens the session; its action is discarded.
        if (any_pulse) begin
          state_next  = S_EDIT;
          cursor_next = '0;
          timer_next  = '0;
        end
      end

      S_EDIT: begin
        // One action per cycle; lower-priority pulses in the same cycle are lost.
        if (enter_pulse) begin
          state_next  = S_COMMIT;
          commit_next = digits_reg;
          timer_next  = '0;
        end else if (next_pulse) begin
          cursor_next = (cursor_reg == CURSOR_LAST) ? '0 : cursor_reg + CW'(1);
          timer_next  = '0;
        end else if (up_pulse) begin
          digits_next = up_value;
          timer_next  = '0;
        end else if (down_pulse) begin
          digits_next = down_value;
          timer_next  = '0;
        end else if (timer_reg == TIMEOUT_LAST) begin
          // Abandoned session: throw the edits away.
          state_next  = S_IDLE;
          digits_next = commit_reg;
          timer_next  = '0;
        end else begin
          timer_next  = timer_reg + TW'(1);
        end
      end

      S_COMMIT: begin
        state_next = S_HOLD;
        hold_next  = '0;
      end

      S_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = S_IDLE;
          hold_next  = '0;
        end else begin
          hold_next  = hold_reg + HW'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Flags are registered copies of the upcoming state so they line up
    // exactly with the state they describe.
    editing_next = (state_next == S_EDIT);
    valid_next   = (state_next == S_COMMIT);
  end

  assign digits       = digits_reg;
  assign cursor       = cursor_reg;
  assign editing      = editing_reg;
  assign commit_valid = valid_reg;
  assign commit_value = commit_reg;

endmodule
